aes128_dec_iter: RTL

//  Iterative AES-128 decryption core (FIPS-197 inverse cipher); counterpart of the combinational encrypt pipeline.

---
 rtl/aes128_dec_iter.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/aes128_dec_iter.sv
// Iterative AES-128 inverse cipher: on-the-fly key expansion, then UNROLL inverse rounds per clock.
// Optional AES_DEC_KEY_CACHE_EN keeps the last round-10 key so a repeated key skips expansion.
`timescale 1ns/1ps

module aes128_dec_iter #(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] cipher,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plain,
  output logic         busy
);

  localparam int unsigned NR = 10 / UNROLL;
  localparam int unsigned CW = 4;

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5) begin : g_bad_unroll
    $error("aes128_dec_iter: UNROLL must be 1, 2 or 5");
  end

  typedef enum logic [1:0] {IDLE, EXPAND, ROUND, DONE} state_t;

  // Byte-indexed lookup ROMs; entry 0 is the leftmost byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_lu(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox_lu(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse of xtime: walks rcon back down the schedule.
  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    return b[0] ? ({1'b0, b[7:1]} ^ 8'h8d) : {1'b0, b[7:1]};
  endfunction

  // Multiply by a constant built from {8,4,2,1} terms of the xtime chain.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (m[3] ? x8 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[0] ? a : 8'h00);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox_lu(w[23:16]), sbox_lu(w[15:8]), sbox_lu(w[7:0]), sbox_lu(w[31:24])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rc, 24'h000000};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] key_inv(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = rk[31:0] ^ rk[63:32];
    w2 = rk[63:32] ^ rk[95:64];
    w1 = rk[95:64] ^ rk[127:96];
    w0 = rk[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

  // InvShiftRows + InvSubBytes + AddRoundKey, then optional InvMixColumns.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic mix);
    logic [127:0] t, o;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[127-8*(4*c+r) -: 8] = inv_sbox_lu(s[127-8*(4*((c+4-r)%4)+r) -: 8]);
      end
    end
    t = t ^ rk;
    o = t;
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        o[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
      end
    end
    return o;
  endfunction

  state_t          state_q, state_d;
  logic [127:0]    rk_q, rk_d, st_q, st_d, plain_d;
  logic [7:0]      rcon_q, rcon_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_valid_d, in_ready_d, busy_d;
  logic [127:0]    exp_rk, rnd_st, rnd_rk;
  logic [7:0]      exp_rcon, rnd_rcon;
  logic            last_cyc;

`ifdef AES_DEC_KEY_CACHE_EN
  logic            cache_vld_q, cache_vld_d;
  logic [127:0]    cache_key_q, cache_key_d, cache_rk_q, cache_rk_d;
  logic            cache_hit;

  assign cache_hit = cache_vld_q && (key == cache_key_q);
`endif

  assign last_cyc = (cnt_q == CW'(NR - 1));

  // Forward key expansion, UNROLL steps chained per clock.
  always_comb begin : key_expand_chain
    exp_rk   = rk_q;
    exp_rcon = rcon_q;
    for (int unsigned k = 0; k < UNROLL; k++) begin
      exp_rk   = key_fwd(exp_rk, exp_rcon);
      exp_rcon = xtime(exp_rcon);
    end
  end

  // Inverse rounds with the key schedule run backwards alongside; last round skips InvMixColumns.
  always_comb begin : inv_round_chain
    rnd_st   = st_q;
    rnd_rk   = rk_q;
    rnd_rcon = rcon_q;
    for (int unsigned k = 0; k < UNROLL; k++) begin
      rnd_rk   = key_inv(rnd_rk, rnd_rcon);
      rnd_st   = inv_round(rnd_st, rnd_rk, !(last_cyc && (k == UNROLL - 1)));
      rnd_rcon = inv_xtime(rnd_rcon);
    end
  end

  always_comb begin : fsm_next
    state_d     = state_q;
    rk_d        = rk_q;
    st_d        = st_q;
    rcon_d      = rcon_q;
    cnt_d       = cnt_q;
    plain_d     = plain;
    out_valid_d = out_valid;
`ifdef AES_DEC_KEY_CACHE_EN
    cache_vld_d = cache_vld_q;
    cache_key_d = cache_key_q;
    cache_rk_d  = cache_rk_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rk_d    = key;
          st_d    = cipher;
          rcon_d  = 8'h01;
          cnt_d   = '0;
          state_d = EXPAND;
`ifdef AES_DEC_KEY_CACHE_EN
          if (cache_hit) begin
            rk_d    = cache_rk_q;
            st_d    = cipher ^ cache_rk_q;
            rcon_d  = 8'h36;
            state_d = ROUND;
          end else begin
            cache_vld_d = 1'b0;
            cache_key_d = key;
          end
`endif
        end
      end
      EXPAND: begin
        rk_d   = exp_rk;
        rcon_d = exp_rcon;
        cnt_d  = cnt_q + 4'd1;
        if (last_cyc) begin
          st_d    = st_q ^ exp_rk;
          rcon_d  = 8'h36;
          cnt_d   = '0;
          state_d = ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
          cache_rk_d  = exp_rk;
          cache_vld_d = 1'b1;
`endif
        end
      end
      ROUND: begin
        if (cnt_q == CW'(NR)) begin
          plain_d     = st_q;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = DONE;
        end else begin
          st_d   = rnd_st;
          rk_d   = rnd_rk;
          rcon_d = rnd_rcon;
          cnt_d  = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      state_q   <= IDLE;
      rk_q      <= '0;
      st_q      <= '0;
      rcon_q    <= '0;
      cnt_q     <= '0;
      plain     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_vld_q <= 1'b0;
      cache_key_q <= '0;
      cache_rk_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rk_q      <= rk_d;
      st_q      <= st_d;
      rcon_q    <= rcon_d;
      cnt_q     <= cnt_d;
      plain     <= plain_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
      busy      <= busy_d;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_vld_q <= cache_vld_d;
      cache_key_q <= cache_key_d;
      cache_rk_q  <= cache_rk_d;
`endif
    end
  end

endmodule
